ecdsa_csr_axil_slave: RTL

- AXI4-Lite responder that owns the ECDSA core's 32-bit control/status registers (COMMAND, ADDR_TABLE_BASE_I, ARGC_I, ADDR_TABLE_BASE_O, ARGC_O, spares).
- Sits between the processor-side `s_axi_csrs_*` bus and the ECDSA datapath.
- Decodes byte addresses, applies write strobes and drives a flat register bus plus a one-cycle command pulse to the core.
- Returns live core status on reads of offset 0.

---
 rtl/ecdsa_csr_axil_slave.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ecdsa_csr_axil_slave.sv
// AXI4-Lite register block for the ECDSA core: COMMAND, argument table bases/counts and spares.
// Reg 0 writes raise cmd_pulse; reads of reg 0 return live core status instead of the stored value.
module ecdsa_csr_axil_slave #(
    parameter int ADDR_W = 12,
    parameter int NREGS  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     s_axi_csrs_awaddr,
    input  logic                  s_axi_csrs_awvalid,
    output logic                  s_axi_csrs_awready,
    input  logic [31:0]           s_axi_csrs_wdata,
    input  logic [3:0]            s_axi_csrs_wstrb,
    input  logic                  s_axi_csrs_wvalid,
    output logic                  s_axi_csrs_wready,
    output logic [1:0]            s_axi_csrs_bresp,
    output logic                  s_axi_csrs_bvalid,
    input  logic                  s_axi_csrs_bready,
    input  logic [ADDR_W-1:0]     s_axi_csrs_araddr,
    input  logic                  s_axi_csrs_arvalid,
    output logic                  s_axi_csrs_arready,
    output logic [31:0]           s_axi_csrs_rdata,
    output logic [1:0]            s_axi_csrs_rresp,
    output logic                  s_axi_csrs_rvalid,
    input  logic                  s_axi_csrs_rready,
    output logic [NREGS*32-1:0]   csr_regs,
    output logic                  cmd_pulse,
    input  logic [31:0]           status_in
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;

    w_state_t w_state, w_state_next;
    r_state_t r_state, r_state_next;

    logic [NREGS-1:0][31:0] regs;
    logic [31:0]            w_idx;
    logic [31:0]            r_idx;
    logic                   w_in_range;
    logic                   r_in_range;
    logic [31:0]            rd_word;
    logic                   unused_addr_bits;

    assign unused_addr_bits = ^{s_axi_csrs_awaddr[1:0], s_axi_csrs_araddr[1:0]};

    always_comb begin
        w_idx      = 32'(s_axi_csrs_awaddr[ADDR_W-1:2]);
        r_idx      = 32'(s_axi_csrs_araddr[ADDR_W-1:2]);
        w_in_range = w_idx < 32'(NREGS);
        r_in_range = r_idx < 32'(NREGS);
        csr_regs   = regs;
    end

    // Reg 0 is never read back; the read port shows core status in its place.
    always_comb begin
        rd_word = '0;
        if (r_idx == 32'd0) begin
            rd_word = status_in;
        end else begin
            for (int unsigned k = 1; k < NREGS; k++) begin
                if (r_idx == k) rd_word = regs[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_next;
            r_state <= r_state_next;
        end
    end

    always_comb begin
        w_state_next = w_state;
        case (w_state)
            W_IDLE:  if (s_axi_csrs_awvalid && s_axi_csrs_wvalid) w_state_next = W_ACK;
            W_ACK:   w_state_next = W_RESP;
            W_RESP:  if (s_axi_csrs_bready) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE:  if (s_axi_csrs_arvalid) r_state_next = R_ACK;
            R_ACK:   r_state_next = R_DATA;
            R_DATA:  if (s_axi_csrs_rready) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi_csrs_awready = (w_state == W_ACK);
        s_axi_csrs_wready  = (w_state == W_ACK);
        s_axi_csrs_bvalid  = (w_state == W_RESP);
        s_axi_csrs_arready = (r_state == R_ACK);
        s_axi_csrs_rvalid  = (r_state == R_DATA);
    end

    // Register file, responses and command pulse all update on the ACK edge of their FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs             <= '0;
            cmd_pulse        <= 1'b0;
            s_axi_csrs_bresp <= RESP_OKAY;
            s_axi_csrs_rresp <= RESP_OKAY;
            s_axi_csrs_rdata <= '0;
        end else begin
            cmd_pulse <= 1'b0;
            if (w_state == W_ACK) begin
                s_axi_csrs_bresp <= w_in_range ? RESP_OKAY : RESP_SLVERR;
                cmd_pulse        <= w_in_range && (w_idx == 32'd0);
                for (int unsigned k = 0; k < NREGS; k++) begin
                    if (w_idx == k) begin
                        for (int unsigned b = 0; b < 4; b++) begin
                            if (s_axi_csrs_wstrb[b]) regs[k][8*b +: 8] <= s_axi_csrs_wdata[8*b +: 8];
                        end
                    end
                end
            end
            if (r_state == R_ACK) begin
                s_axi_csrs_rdata <= rd_word;
                s_axi_csrs_rresp <= r_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

endmodule
